// File: rtl/gf_rca_mult_seq.sv
// Iterative valid/ready multiplier: carry-less GF(2)[x] or unsigned integer product,
// consuming DIGIT bits of the multiplier per cycle and returning the full 2*DATA_WIDTH-bit result.
//   state | meaning
//   IDLE  | ready for operands
//   RUN   | accumulating DIGIT partial products per cycle
//   DONE  | result presented, waiting for out_ready
module gf_rca_mult_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int DIGIT      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      gf_option,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int N     = DATA_WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if ((DATA_WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("gf_rca_mult_seq: DIGIT (%0d) must divide DATA_WIDTH (%0d)", DIGIT, DATA_WIDTH);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           a_sh;
    logic [DATA_WIDTH-1:0]   b_sh;
    logic                    gf_q;
    logic [PW-1:0]           acc;
    logic [PW-1:0]           acc_next;
    logic [PW-1:0]           step_xor;
    logic [PW-1:0]           step_sum;
    logic [CNT_W-1:0]        cnt;

    // a_sh is pre-shifted by cnt*DIGIT and b_sh pre-shifted down, so bit j of b_sh is b[k]
    always_comb begin
        step_xor = '0;
        step_sum = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (b_sh[j]) begin
                step_xor = step_xor ^ (a_sh << j);
                step_sum = step_sum + (a_sh << j);
            end
        end
        acc_next = gf_q ? (acc ^ step_xor) : (acc + step_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            gf_q <= 1'b0;
            acc  <= '0;
            cnt  <= '0;
            out  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= {{DATA_WIDTH{1'b0}}, a};
                        b_sh <= b;
                        gf_q <= gf_option;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) out <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_rca_mult_seq.sv
// Scoreboard bench: directed vectors on an 8-bit/DIGIT=2 instance plus a default-parameter run.
module tb_gf_rca_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        in_valid_s, in_ready_s, gf_s, out_valid_s, out_ready_s;
    logic [7:0]  a_s, b_s;
    logic [15:0] out_s;

    logic        in_valid_l, in_ready_l, gf_l, out_valid_l, out_ready_l;
    logic [31:0] a_l, b_l;
    logic [63:0] out_l;

    logic [15:0] q_s[$];
    logic [63:0] q_l[$];
    int          last_acc_s = 0, gap_s = 0, last_acc_l = 0, gap_l = 0;
    bit          rand_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf_rca_mult_seq #(.DATA_WIDTH(8), .DIGIT(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .gf_option(gf_s), .a(a_s), .b(b_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .out(out_s)
    );

    gf_rca_mult_seq dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .gf_option(gf_l), .a(a_l), .b(b_l), .out_valid(out_valid_l),
        .out_ready(out_ready_l), .out(out_l)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_l(input logic g, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        r = '0;
        if (g) begin
            for (int i = 0; i < 32; i++)
                if (y[i]) r = r ^ ({32'b0, x} << i);
        end else begin
            r = {32'b0, x} * {32'b0, y};
        end
        return r;
    endfunction

    // Monitors: compare on every output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid_s && out_ready_s) begin
            if (q_s.size() == 0) begin
                checks++; errors++;
                $display("FAIL small_unexpected_result: got %0h expected none", out_s);
            end else begin
                check("small_result", {48'b0, out_s}, {48'b0, q_s.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_l && out_ready_l) begin
            if (q_l.size() == 0) begin
                checks++; errors++;
                $display("FAIL large_unexpected_result: got %0h expected none", out_l);
            end else begin
                check("large_result", out_l, q_l.pop_front());
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        out_ready_l = rand_ready ? 1'($urandom) : 1'b1;
    end

    task automatic issue_s(input logic g, input logic [7:0] aa, input logic [7:0] bb,
                           input logic [15:0] exp, input bit push);
        int t = 0;
        while (!in_ready_s && t < 100) begin @(posedge clk); #1; t++; end
        if (!in_ready_s) check("small_accept_timeout", {63'b0, in_ready_s}, 64'd1);
        gf_s = g; a_s = aa; b_s = bb; in_valid_s = 1'b1;
        if (push) q_s.push_back(exp);
        @(posedge clk); #1;
        gap_s = cyc - last_acc_s;
        last_acc_s = cyc;
        in_valid_s = 1'b0;
    endtask

    task automatic issue_l(input logic g, input logic [31:0] aa, input logic [31:0] bb);
        int t = 0;
        while (!in_ready_l && t < 200) begin @(posedge clk); #1; t++; end
        if (!in_ready_l) check("large_accept_timeout", {63'b0, in_ready_l}, 64'd1);
        gf_l = g; a_l = aa; b_l = bb; in_valid_l = 1'b1;
        q_l.push_back(ref_l(g, aa, bb));
        @(posedge clk); #1;
        gap_l = cyc - last_acc_l;
        last_acc_l = cyc;
        in_valid_l = 1'b0;
    endtask

    initial begin
        int n;
        bit bad;
        logic [15:0] held;

        rst_n = 1'b0;
        in_valid_s = 0; gf_s = 0; a_s = 0; b_s = 0; out_ready_s = 1'b1;
        in_valid_l = 0; gf_l = 0; a_l = 0; b_l = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {63'b0, in_ready_s}, 64'd1);
        check("reset_out_valid", {63'b0, out_valid_s}, 64'd0);
        check("reset_out", {48'b0, out_s}, 64'd0);
        check("reset_out_large", out_l, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: gf product, latency and in_ready during RUN
        issue_s(1'b1, 8'h57, 8'h83, 16'h2B79, 1'b1);
        n = 0; bad = 1'b0;
        while (!out_valid_s && n < 50) begin
            if (in_ready_s) bad = 1'b1;
            @(posedge clk); #1; n++;
        end
        check("latency", n, 4);
        check("in_ready_low_run", {63'b0, bad | in_ready_s}, 64'd0);

        // 2: integer mode, all-ones, zero operands, back-to-back gap
        issue_s(1'b0, 8'h57, 8'h83, 16'h2C85, 1'b1);
        issue_s(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
        check("b2b_gap_small", gap_s, 6);
        issue_s(1'b1, 8'hFF, 8'hFF, 16'h5555, 1'b1);
        issue_s(1'b0, 8'h00, 8'hAB, 16'h0000, 1'b1);
        issue_s(1'b1, 8'hCD, 8'h00, 16'h0000, 1'b1);

        // 3: backpressure
        n = 0;
        while (!in_ready_s && n < 50) begin @(posedge clk); #1; n++; end
        out_ready_s = 1'b0;
        issue_s(1'b0, 8'hA5, 8'h3C, 16'h26AC, 1'b1);
        n = 0;
        while (!out_valid_s && n < 50) begin @(posedge clk); #1; n++; end
        held = out_s;
        check("bp_value", {48'b0, held}, 64'h26AC);
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_s !== held || !out_valid_s || in_ready_s) bad = 1'b1;
        end
        check("bp_hold", {63'b0, bad}, 64'd0);
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", {63'b0, in_ready_s}, 64'd1);
        check("bp_release_out_valid", {63'b0, out_valid_s}, 64'd0);
        check("bp_out_keeps", {48'b0, out_s}, 64'h26AC);

        // 4: operand churn while busy
        issue_s(1'b1, 8'h57, 8'h83, 16'h2B79, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a_s = 8'($urandom); b_s = 8'($urandom); gf_s = 1'($urandom);
            in_valid_s = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_s = 1'b0;

        // 5: reset mid-RUN
        issue_s(1'b0, 8'h57, 8'h83, 16'h0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out", {48'b0, out_s}, 64'd0);
        check("abort_out_valid", {63'b0, out_valid_s}, 64'd0);
        check("abort_in_ready", {63'b0, in_ready_s}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue_s(1'b0, 8'h12, 8'h34, 16'h03A8, 1'b1);

        // Default parameters: directed, gap, then random with gaps and backpressure
        issue_l(1'b1, 32'h57, 32'h83);
        issue_l(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("b2b_gap_large", gap_l, 10);
        issue_l(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue_l(1'b0, 32'h0, 32'hDEAD_BEEF);
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue_l(1'($urandom), $urandom, $urandom);
        end

        n = 0;
        while ((q_s.size() != 0 || q_l.size() != 0) && n < 2000) begin @(posedge clk); n++; end
        check("queues_drained", q_s.size() + q_l.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
